fifo_prog: RTL and testbench
============================

Name: fifo_prog

Overview:
- Parametrised successor to the transmit-layer FIFO: synchronous single-clock buffer with run-time programmable almost-full/almost-empty thresholds.
- Adds overflow/underflow protection, a sticky error flag, an occupancy output and a read-data valid strobe.
- Sits between the PCIe transmit-layer producer (mux/serialiser side) and its consumer. Flow control is driven from the almost flags.

Parameters:
- data_width, 6, bits per entry.
- address_width, 3, pointer width; depth = 2**address_width (default 8).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset; asserting low clears all state immediately.
- wr_enable  input  1  write request.
- rd_enable  input  1  read request.
- data_in  input  data_width  write data.
- af_threshold  input  address_width+1  almost-full level.
- ae_threshold  input  address_width+1  almost-empty level.
- data_out  output  data_width  registered read data.
- valid_out  output  1  data_out updated this cycle.
- full_fifo  output  1  count == depth.
- empty_fifo  output  1  count == 0.
- almost_full_fifo  output  1  count >= af_threshold.
- almost_empty_fifo  output  1  count <= ae_threshold.
- error  output  1  sticky overflow/underflow indicator.
- count  output  address_width+1  current occupancy, 0..depth.

Behaviour:
- Reset (reset low, async):
  - wr_ptr, rd_ptr, count, data_out, valid_out and error all go to 0.
  - Hence empty_fifo=1 and full_fifo=0. almost_empty_fifo=1 for any ae_threshold; almost_full_fifo=1 only if af_threshold==0.
  - Memory contents are not reset.
  - Reset mid-operation discards all stored data; first write after deassertion lands at address 0.
- Accept rules, evaluated on the same edge:
  - wr_acc = wr_enable & (!full_fifo | rd_enable).
  - rd_acc = rd_enable & !empty_fifo.
- Write: on wr_acc, mem[wr_ptr] <= data_in and wr_ptr increments. Pointers wrap naturally mod depth.
- Read:
  - On rd_acc, data_out <= mem[rd_ptr], rd_ptr increments, and valid_out=1 in the following cycle.
  - Latency is 1 cycle from accepted read to data.
  - Without rd_acc, data_out holds its value and valid_out=0.
- count update: +1 on wr_acc & !rd_acc; -1 on rd_acc & !wr_acc; unchanged otherwise. count never exceeds depth and never underflows.
- Full with simultaneous read+write: both accepted, count stays at depth, and the read returns the oldest entry, never the one being written.
- Empty with simultaneous read+write: write accepted, read rejected (no fall-through), count becomes 1, valid_out=0.
- Overflow: wr_enable & full_fifo & !rd_enable sets error; the write is dropped and pointers are unchanged.
- Underflow: rd_enable & empty_fifo sets error; the read is dropped.
- error stays 1 until reset.
- Flags:
  - All flags are combinational from the registered count and the threshold inputs.
  - Thresholds may change at any time and take effect immediately.
  - Threshold values above depth are legal: almost_full_fifo then never asserts, and almost_empty_fifo stays asserted.

Decomposition:
- Shared include/package holds only the depth localparam derivation (2**address_width) and count-width helper. No typedefs.
- One natural sub-module: fifo_prog_mem, a dual-port register array (one write port, one registered read port) parametrised by data_width/address_width.
- Pointer, count, flag and error logic stay in fifo_prog.

Test Plan:
- Reset then idle: count=0, empty_fifo=1, full_fifo=0, error=0, data_out=0, valid_out=0.
- Fill: 8 writes of 0x01..0x08 with af=6, ae=1.
  - almost_full_fifo rises when count reaches 6, full_fifo at count=8.
  - almost_empty_fifo drops when count reaches 2.
  - A 9th write (no read) sets error=1, count stays 8, and later drains show data 0x01..0x08 only.
- Drain ordering: 8 reads from full produce 0x01..0x08, each one cycle after rd_enable with valid_out=1.
  - A 9th read sets error, valid_out=0 and data_out holds 0x08.
- Simultaneous at full: wr 0x2A + rd for one cycle at count=8 gives count=8, data_out=oldest entry and error unchanged. 0x2A appears last in the drain.
- Simultaneous at empty: wr 0x15 + rd at count=0 gives count=1, valid_out=0 and error=1. The next read returns 0x15.
- Async reset mid-stream: reset low between clock edges at count=5 clears count, flags and error immediately without a clock edge. Write 0x33 after release, then read, returns 0x33.

Source files
------------

// File: rtl/fifo_prog_pkg.sv
// Shared sizing helpers for the programmable-threshold FIFO.
// Depth and count width are derived from the pointer width.
package fifo_prog_pkg;

    function automatic int fifo_depth(input int address_width);
        return 32'sd1 << address_width;
    endfunction

    // Occupancy runs 0..depth inclusive, so it needs one bit more than a pointer.
    function automatic int count_width(input int address_width);
        return address_width + 32'sd1;
    endfunction

endpackage

// File: rtl/fifo_prog_mem.sv
// Register-array storage for fifo_prog: one write port and one registered read port.
// The array itself is not reset; only the read-data register clears.
module fifo_prog_mem
    import fifo_prog_pkg::*;
#(
    parameter int data_width    = 6,
    parameter int address_width = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [address_width-1:0] wr_addr,
    input  logic [data_width-1:0]    wr_data,
    input  logic                     rd_en,
    input  logic [address_width-1:0] rd_addr,
    output logic [data_width-1:0]    rd_data
);

    localparam int DEPTH = fifo_depth(address_width);

    logic [data_width-1:0] mem_q [DEPTH];
    logic [data_width-1:0] rd_data_d;
    logic [data_width-1:0] rd_data_q;

    // Storage write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Next read data: old array content on a read, otherwise hold.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end else begin
            rd_data_d = rd_data_q;
        end
    end

    // Read-data register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/fifo_prog.sv
// Single-clock FIFO with run-time almost-full/almost-empty thresholds,
// overflow/underflow protection, sticky error, occupancy and read-valid strobe.
module fifo_prog
    import fifo_prog_pkg::*;
#(
    parameter int data_width    = 6,
    parameter int address_width = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_enable,
    input  logic                   rd_enable,
    input  logic [data_width-1:0]  data_in,
    input  logic [address_width:0] af_threshold,
    input  logic [address_width:0] ae_threshold,
    output logic [data_width-1:0]  data_out,
    output logic                   valid_out,
    output logic                   full_fifo,
    output logic                   empty_fifo,
    output logic                   almost_full_fifo,
    output logic                   almost_empty_fifo,
    output logic                   error,
    output logic [address_width:0] count
);

    localparam int CW = count_width(address_width);
    localparam logic [CW-1:0]            DEPTH_C = CW'(fifo_depth(address_width));
    localparam logic [CW-1:0]            CNT_ONE = CW'(1);
    localparam logic [address_width-1:0] PTR_ONE = address_width'(1);

    logic [address_width-1:0] wr_ptr_q, wr_ptr_d;
    logic [address_width-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]            count_q, count_d;
    logic                     valid_q, valid_d;
    logic                     error_q, error_d;
    logic                     full_s, empty_s;
    logic                     wr_acc_s, rd_acc_s;

    assign full_s  = (count_q == DEPTH_C);
    assign empty_s = (count_q == '0);

    // Accept decisions, pointer/count/error next state.
    always_comb begin
        wr_acc_s = wr_enable & (~full_s | rd_enable);
        rd_acc_s = rd_enable & ~empty_s;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        valid_d  = rd_acc_s;
        error_d  = error_q | (wr_enable & full_s & ~rd_enable) | (rd_enable & empty_s);

        if (wr_acc_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (rd_acc_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        // Both accepted (only possible when not empty) leaves occupancy unchanged.
        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
        end
    end

    fifo_prog_mem #(
        .data_width   (data_width),
        .address_width(address_width)
    ) u_mem (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (wr_acc_s),
        .wr_addr(wr_ptr_q),
        .wr_data(data_in),
        .rd_en  (rd_acc_s),
        .rd_addr(rd_ptr_q),
        .rd_data(data_out)
    );

    // Flags follow the registered count and live threshold inputs.
    assign full_fifo         = full_s;
    assign empty_fifo        = empty_s;
    assign almost_full_fifo  = (count_q >= af_threshold);
    assign almost_empty_fifo = (count_q <= ae_threshold);
    assign valid_out         = valid_q;
    assign error             = error_q;
    assign count             = count_q;

endmodule

// File: tb/tb_fifo_prog.sv
// Directed bench for fifo_prog: a fill/overflow/drain/underflow vector table
// followed by hand-written sequences for simultaneous access, thresholds and async reset.
module tb_fifo_prog;

    logic       clk;
    logic       reset;
    logic       wr_enable;
    logic       rd_enable;
    logic [5:0] data_in;
    logic [3:0] af_threshold;
    logic [3:0] ae_threshold;
    logic [5:0] data_out;
    logic       valid_out;
    logic       full_fifo;
    logic       empty_fifo;
    logic       almost_full_fifo;
    logic       almost_empty_fifo;
    logic       error;
    logic [3:0] count;

    int checks   = 0;
    int failures = 0;

    fifo_prog #(.data_width(6), .address_width(3)) dut (
        .clk              (clk),
        .reset            (reset),
        .wr_enable        (wr_enable),
        .rd_enable        (rd_enable),
        .data_in          (data_in),
        .af_threshold     (af_threshold),
        .ae_threshold     (ae_threshold),
        .data_out         (data_out),
        .valid_out        (valid_out),
        .full_fifo        (full_fifo),
        .empty_fifo       (empty_fifo),
        .almost_full_fifo (almost_full_fifo),
        .almost_empty_fifo(almost_empty_fifo),
        .error            (error),
        .count            (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic       rd;
        logic [5:0] din;
        logic [3:0] cnt;
        logic [5:0] dout;
        logic       valid;
        logic       full;
        logic       empty;
        logic       af;
        logic       ae;
        logic       err;
    } vec_t;

    vec_t vecs[19];
    logic [5:0] exp_drain[8];

    function automatic vec_t mk(input logic wr, input logic rd, input logic [5:0] din,
                                input logic [3:0] cnt, input logic [5:0] dout, input logic valid,
                                input logic full, input logic empty, input logic af,
                                input logic ae, input logic err);
        vec_t v;
        v.wr = wr; v.rd = rd; v.din = din; v.cnt = cnt; v.dout = dout; v.valid = valid;
        v.full = full; v.empty = empty; v.af = af; v.ae = ae; v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [3:0] cnt, input logic [5:0] dout,
                               input logic valid, input logic full, input logic empty,
                               input logic af, input logic ae, input logic err);
        chk({tag, "_count"}, 32'(count), 32'(cnt));
        chk({tag, "_dout"},  32'(data_out), 32'(dout));
        chk({tag, "_valid"}, 32'(valid_out), 32'(valid));
        chk({tag, "_full"},  32'(full_fifo), 32'(full));
        chk({tag, "_empty"}, 32'(empty_fifo), 32'(empty));
        chk({tag, "_af"},    32'(almost_full_fifo), 32'(af));
        chk({tag, "_ae"},    32'(almost_empty_fifo), 32'(ae));
        chk({tag, "_err"},   32'(error), 32'(err));
    endtask

    task automatic cycle(input logic wr, input logic rd, input logic [5:0] din);
        wr_enable = wr;
        rd_enable = rd;
        data_in   = din;
        @(posedge clk);
        #1;
    endtask

    // Pull reset low between edges and check the cleared state before any clock edge.
    task automatic async_reset(input string tag, input logic exp_af);
        @(negedge clk);
        wr_enable = 1'b0;
        rd_enable = 1'b0;
        reset = 1'b0;
        #1;
        check_state(tag, 4'd0, 6'h00, 1'b0, 1'b0, 1'b1, exp_af, 1'b1, 1'b0);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        reset        = 1'b0;
        wr_enable    = 1'b0;
        rd_enable    = 1'b0;
        data_in      = 6'h00;
        af_threshold = 4'd6;
        ae_threshold = 4'd1;

        // Fill 0x01..0x08 with af=6/ae=1, overflow with 0x09, drain, then underflow.
        //            wr    rd    din    cnt   dout   vld   full  empty af    ae    err
        vecs[0]  = mk(1'b1, 1'b0, 6'h01, 4'd1, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[1]  = mk(1'b1, 1'b0, 6'h02, 4'd2, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[2]  = mk(1'b1, 1'b0, 6'h03, 4'd3, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[3]  = mk(1'b1, 1'b0, 6'h04, 4'd4, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[4]  = mk(1'b1, 1'b0, 6'h05, 4'd5, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[5]  = mk(1'b1, 1'b0, 6'h06, 4'd6, 6'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        vecs[6]  = mk(1'b1, 1'b0, 6'h07, 4'd7, 6'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        vecs[7]  = mk(1'b1, 1'b0, 6'h08, 4'd8, 6'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        vecs[8]  = mk(1'b1, 1'b0, 6'h09, 4'd8, 6'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        vecs[9]  = mk(1'b0, 1'b1, 6'h00, 4'd7, 6'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        vecs[10] = mk(1'b0, 1'b1, 6'h00, 4'd6, 6'h02, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        vecs[11] = mk(1'b0, 1'b1, 6'h00, 4'd5, 6'h03, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[12] = mk(1'b0, 1'b1, 6'h00, 4'd4, 6'h04, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[13] = mk(1'b0, 1'b1, 6'h00, 4'd3, 6'h05, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[14] = mk(1'b0, 1'b1, 6'h00, 4'd2, 6'h06, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[15] = mk(1'b0, 1'b1, 6'h00, 4'd1, 6'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        vecs[16] = mk(1'b0, 1'b1, 6'h00, 4'd0, 6'h08, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        vecs[17] = mk(1'b0, 1'b1, 6'h00, 4'd0, 6'h08, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        vecs[18] = mk(1'b0, 1'b0, 6'h00, 4'd0, 6'h08, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);

        exp_drain[0] = 6'h11; exp_drain[1] = 6'h12; exp_drain[2] = 6'h13; exp_drain[3] = 6'h14;
        exp_drain[4] = 6'h15; exp_drain[5] = 6'h16; exp_drain[6] = 6'h17; exp_drain[7] = 6'h2A;

        // Reset then idle.
        #12;
        check_state("reset", 4'd0, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        reset = 1'b1;
        cycle(1'b0, 1'b0, 6'h00);
        check_state("idle", 4'd0, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 19; i++) begin
            cycle(vecs[i].wr, vecs[i].rd, vecs[i].din);
            check_state($sformatf("v%0d", i), vecs[i].cnt, vecs[i].dout, vecs[i].valid,
                        vecs[i].full, vecs[i].empty, vecs[i].af, vecs[i].ae, vecs[i].err);
        end

        // Simultaneous read+write at empty: write only, error set, no fall-through.
        async_reset("rst1", 1'b0);
        cycle(1'b1, 1'b1, 6'h15);
        check_state("sim_empty", 4'd1, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 6'h00);
        check_state("sim_empty_rd", 4'd0, 6'h15, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);

        // Fill, probe live thresholds, then simultaneous read+write at full.
        async_reset("rst2", 1'b0);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0, 6'h10 + 6'(i));
        end
        check_state("fill2", 4'd8, 6'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        wr_enable = 1'b0;
        af_threshold = 4'd9;  #1; chk("af9",  32'(almost_full_fifo), 32'd0);
        af_threshold = 4'd15; #1; chk("af15", 32'(almost_full_fifo), 32'd0);
        af_threshold = 4'd8;  #1; chk("af8",  32'(almost_full_fifo), 32'd1);
        ae_threshold = 4'd15; #1; chk("ae15", 32'(almost_empty_fifo), 32'd1);
        ae_threshold = 4'd7;  #1; chk("ae7",  32'(almost_empty_fifo), 32'd0);
        ae_threshold = 4'd8;  #1; chk("ae8",  32'(almost_empty_fifo), 32'd1);
        af_threshold = 4'd6;
        ae_threshold = 4'd1;
        cycle(1'b1, 1'b1, 6'h2A);
        check_state("sim_full", 4'd8, 6'h10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, 6'h00);
            chk($sformatf("drain%0d_dout", i), 32'(data_out), 32'(exp_drain[i]));
            chk($sformatf("drain%0d_valid", i), 32'(valid_out), 32'd1);
        end
        cycle(1'b0, 1'b0, 6'h00);
        check_state("drained", 4'd0, 6'h2A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

        // Async reset mid-stream at count 5 after an underflow error.
        async_reset("rst3", 1'b0);
        cycle(1'b0, 1'b1, 6'h00);
        chk("underflow_err", 32'(error), 32'd1);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, 6'h20 + 6'(i));
        end
        chk("mid_count", 32'(count), 32'd5);
        cycle(1'b0, 1'b1, 6'h00);
        chk("mid_dout", 32'(data_out), 32'h20);
        cycle(1'b1, 1'b0, 6'h24);
        async_reset("rst_mid", 1'b0);
        af_threshold = 4'd0; #1;
        chk("af0_reset", 32'(almost_full_fifo), 32'd1);
        af_threshold = 4'd6;
        cycle(1'b1, 1'b0, 6'h33);
        cycle(1'b0, 1'b1, 6'h00);
        check_state("post_rst", 4'd0, 6'h33, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 6'h00);
        chk("post_rst_valid_drop", 32'(valid_out), 32'd0);
        chk("post_rst_hold", 32'(data_out), 32'h33);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
